// File: rtl/adc_spi_responder.sv
// -----------------------------------------------------------------------------
// adc_spi_responder
//
// Emulates the 12-bit serial ADC that a PID controller channel reads over SPI.
// The controller drives sck/cs. This block answers on dout with a frame of
// LEAD_ZEROS zero bits followed by DATA_BITS sample bits, MSB first. A new bit
// is launched on every sck falling edge, so the controller samples while sck
// is high.
//
// Optional feature: define ADC_NOISE_EN to add LFSR-based noise to every frame.
// The frame value becomes clamp(staging + lfsr[NOISE_BITS-1:0] - 2**(NOISE_BITS-1)).
// Without ADC_NOISE_EN, each frame returns the staging value exactly.
//
// Ports
//   clk          system clock, the only clock
//   rst          asynchronous active-high reset
//   sck          SPI clock from the controller, idles high, asynchronous
//   cs           SPI chip select, active low, asynchronous
//   dout         serial data back to the controller (never tri-stated)
//   sample_in    sample value for upcoming frames
//   sample_load  1-clk strobe that captures sample_in into the staging register
//   busy         high while a frame is in progress (SHIFT or DONE)
//   frame_done   1-clk pulse, cs rose after a complete frame
//   frame_abort  1-clk pulse, cs rose before the frame was complete
//   frame_count  completed-frame counter, wraps at 16 bits
// -----------------------------------------------------------------------------
module adc_spi_responder #(
  parameter int DATA_BITS  = 12,
  parameter int LEAD_ZEROS = 4
`ifdef ADC_NOISE_EN
  ,
  parameter int          NOISE_BITS = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sck,
  input  logic                 cs,
  output logic                 dout,
  input  logic [DATA_BITS-1:0] sample_in,
  input  logic                 sample_load,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_abort,
  output logic [15:0]          frame_count
);

  localparam int FRAME_BITS = LEAD_ZEROS + DATA_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bits [1:0] synchronise the pin. Bit [2] holds the previous synchronised
  // value for edge detection.
  logic [2:0]            sck_sync_q;
  logic [2:0]            cs_sync_q;
  logic [DATA_BITS-1:0]  staging_q;
  state_t                state_q;
  logic [FRAME_BITS-2:0] shift_q;      // bits still to be sent after the current one
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  dout_q;
  logic                  busy_q;
  logic                  frame_done_q;
  logic                  frame_abort_q;
  logic [15:0]           frame_count_q;

  logic                  sck_fall_s;
  logic                  cs_fall_s;
  logic                  cs_rise_s;
  logic                  frame_start_s;
  logic [DATA_BITS-1:0]  frame_value_s;
  logic [FRAME_BITS-1:0] frame_word_s;

  // Synchronise sck (idle high) and cs. cs resets low, so a cs that is held low
  // through reset cannot produce a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q <= 3'b111;
      cs_sync_q  <= 3'b000;
    end else begin
      sck_sync_q <= {sck_sync_q[1:0], sck};
      cs_sync_q  <= {cs_sync_q[1:0], cs};
    end
  end

  assign sck_fall_s    = sck_sync_q[2] & ~sck_sync_q[1];
  assign cs_fall_s     = cs_sync_q[2] & ~cs_sync_q[1];
  assign cs_rise_s     = ~cs_sync_q[2] & cs_sync_q[1];
  assign frame_start_s = (state_q == ST_IDLE) & cs_fall_s;

  // Staging register. A frame starting in the same clk still uses the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staging_q <= {DATA_BITS{1'b0}};
    end else if (sample_load) begin
      staging_q <= sample_in;
    end
  end

`ifdef ADC_NOISE_EN
  localparam logic signed [DATA_BITS+1:0] NOISE_OFS = (DATA_BITS+2)'(2**(NOISE_BITS-1));

  logic [15:0] lfsr_q;

  // Adds centred noise to base_v in a signed domain two bits wider than the
  // sample, then saturates to 0..2**DATA_BITS-1 so the result never wraps.
  function automatic logic [DATA_BITS-1:0] apply_noise(
    input logic [DATA_BITS-1:0]  base_v,
    input logic [NOISE_BITS-1:0] noise_v
  );
    logic signed [DATA_BITS+1:0] sum_v;
    sum_v = $signed({2'b00, base_v})
          + $signed({{(DATA_BITS+2-NOISE_BITS){1'b0}}, noise_v})
          - NOISE_OFS;
    if (sum_v[DATA_BITS+1]) begin
      apply_noise = {DATA_BITS{1'b0}};
    end else if (sum_v[DATA_BITS]) begin
      apply_noise = {DATA_BITS{1'b1}};
    end else begin
      apply_noise = sum_v[DATA_BITS-1:0];
    end
  endfunction

  // 16-bit Fibonacci LFSR (taps 16,14,13,11) that steps once per frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (frame_start_s) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign frame_value_s = apply_noise(staging_q, lfsr_q[NOISE_BITS-1:0]);
`else
  assign frame_value_s = staging_q;
`endif

  assign frame_word_s = FRAME_BITS'(frame_value_s);

  // Frame FSM. All outputs are registered. A cs rise takes priority over an
  // sck fall seen in the same clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      shift_q       <= {(FRAME_BITS-1){1'b0}};
      bit_cnt_q     <= {CNT_W{1'b0}};
      dout_q        <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          dout_q <= 1'b0;
          if (frame_start_s) begin
            dout_q    <= frame_word_s[FRAME_BITS-1];
            shift_q   <= frame_word_s[FRAME_BITS-2:0];
            bit_cnt_q <= {CNT_W{1'b0}};
            busy_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cs_rise_s) begin
            frame_abort_q <= 1'b1;
            dout_q        <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= ST_IDLE;
          end else if (sck_fall_s) begin
            if (bit_cnt_q == LAST_BIT) begin
              dout_q  <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              dout_q    <= shift_q[FRAME_BITS-2];
              shift_q   <= shift_q << 1;
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          dout_q <= 1'b0;
          if (cs_rise_s) begin
            frame_done_q  <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
            busy_q        <= 1'b0;
            state_q       <= ST_IDLE;
          end
        end
        default: begin
          dout_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dout        = dout_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign frame_count = frame_count_q;

endmodule
